// File: rtl/health_pkg.sv
// Shared types and default constants for the multi-player lives manager.
package health_pkg;

    typedef enum logic [1:0] {
        ALIVE   = 2'd0,
        CONTACT = 2'd1,
        INVULN  = 2'd2,
        DEAD    = 2'd3
    } health_state_e;

    localparam int DEF_NUM_PLAYERS = 2;
    localparam int DEF_LIVES_W     = 3;
    localparam int DEF_MAX_LIVES   = 3;
    localparam int DEF_TOLERANCE   = 60;
    localparam int DEF_IFRAMES     = 90;
    localparam int DEF_CNT_W       = 7;

endpackage

// File: rtl/health_manager_if.sv
// Game-logic side bundle of the lives manager: frame sync, per-player requests, HUD/sound outputs.
interface health_manager_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int LIVES_W     = 3
);
    logic                           vsync;
    logic [NUM_PLAYERS-1:0]         collision;
    logic [NUM_PLAYERS-1:0]         heal;
    logic                           restart;
    logic [NUM_PLAYERS*LIVES_W-1:0] lives;
    logic [NUM_PLAYERS-1:0]         invincible;
    logic [NUM_PLAYERS-1:0]         hit;
    logic                           game_over;

    modport master (
        output vsync, collision, heal, restart,
        input  lives, invincible, hit, game_over
    );

    modport slave (
        input  vsync, collision, heal, restart,
        output lives, invincible, hit, game_over
    );
endinterface

// File: rtl/health_channel.sv
// One player's contact/damage FSM, frame counter, lives register and sticky heal request.
// HEALTH_IFRAMES_EN builds the post-hit invincibility window; otherwise damage returns straight to ALIVE.
module health_channel
    import health_pkg::*;
#(
    parameter int LIVES_W   = DEF_LIVES_W,
    parameter int MAX_LIVES = DEF_MAX_LIVES,
    parameter int TOLERANCE = DEF_TOLERANCE,
    parameter int IFRAMES   = DEF_IFRAMES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_tick,
    input  logic               i_restart,
    input  logic               i_collision,
    input  logic               i_heal,
    output logic [LIVES_W-1:0] o_lives,
    output logic               o_invincible,
    output logic               o_hit,
    output logic               o_dead
);

    health_state_e      r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [LIVES_W-1:0] r_lives;
    logic               r_heal_pend;
    logic               r_hit;
    logic               r_inv;

    logic w_damage;
    logic w_heal_req;
    logic w_can_heal;

`ifndef HEALTH_IFRAMES_EN
    // IFRAMES only matters when the invincibility window is built.
    localparam int UNUSED_IFRAMES = IFRAMES;
`endif

    assign w_damage = i_tick && i_collision &&
                      (((r_state == ALIVE) && (TOLERANCE == 0)) ||
                       ((r_state == CONTACT) && (r_cnt == CNT_W'(TOLERANCE))));
    assign w_heal_req = r_heal_pend | i_heal;
    assign w_can_heal = (r_lives < LIVES_W'(MAX_LIVES)) && (r_state != DEAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ALIVE;
            r_cnt       <= '0;
            r_lives     <= LIVES_W'(MAX_LIVES);
            r_heal_pend <= 1'b0;
            r_hit       <= 1'b0;
            r_inv       <= 1'b0;
        end else if (i_restart) begin
            r_state     <= ALIVE;
            r_cnt       <= '0;
            r_lives     <= LIVES_W'(MAX_LIVES);
            r_heal_pend <= 1'b0;
            r_hit       <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (i_tick) begin
                r_heal_pend <= 1'b0;
                if (w_damage) begin
                    // Damage wins over a heal landing on the same tick.
                    r_hit   <= 1'b1;
                    r_lives <= r_lives - LIVES_W'(1);
                    r_cnt   <= '0;
                    if (r_lives == LIVES_W'(1)) begin
                        r_state <= DEAD;
                        r_inv   <= 1'b0;
                    end else begin
`ifdef HEALTH_IFRAMES_EN
                        r_state <= INVULN;
                        r_inv   <= 1'b1;
`else
                        r_state <= ALIVE;
                        r_inv   <= 1'b0;
`endif
                    end
                end else begin
                    if (w_heal_req && w_can_heal) begin
                        r_lives <= r_lives + LIVES_W'(1);
                    end
                    case (r_state)
                        ALIVE: begin
                            if (i_collision) begin
                                r_state <= CONTACT;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                        CONTACT: begin
                            if (i_collision) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end else begin
                                r_state <= ALIVE;
                                r_cnt   <= '0;
                            end
                        end
`ifdef HEALTH_IFRAMES_EN
                        INVULN: begin
                            if (r_cnt == CNT_W'(IFRAMES - 1)) begin
                                r_state <= ALIVE;
                                r_cnt   <= '0;
                                r_inv   <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
`endif
                        DEAD: begin
                        end
                        default: begin
                            r_state <= ALIVE;
                            r_cnt   <= '0;
                            r_inv   <= 1'b0;
                        end
                    endcase
                end
            end else if (i_heal) begin
                r_heal_pend <= 1'b1;
            end
        end
    end

    assign o_lives      = r_lives;
    assign o_invincible = r_inv;
    assign o_hit        = r_hit;
    assign o_dead       = (r_state == DEAD);

endmodule

// File: rtl/health_manager.sv
// Lives manager top: vsync frame-tick detect, NUM_PLAYERS health_channel instances, lives packing, game_over.
// Optional HEALTH_IFRAMES_EN enables the per-channel invincibility window.
module health_manager
    import health_pkg::*;
#(
    parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int LIVES_W     = DEF_LIVES_W,
    parameter int MAX_LIVES   = DEF_MAX_LIVES,
    parameter int TOLERANCE   = DEF_TOLERANCE,
    parameter int IFRAMES     = DEF_IFRAMES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    health_manager_if.slave bus
);

    logic                           r_vsync_q;
    logic                           r_game_over;
    logic                           w_tick;
    logic [NUM_PLAYERS-1:0]         w_dead;
    logic [NUM_PLAYERS*LIVES_W-1:0] w_lives;
    logic [NUM_PLAYERS-1:0]         w_inv;
    logic [NUM_PLAYERS-1:0]         w_hit;

    // Rising vsync only, so a long-held vsync advances the game by a single frame.
    assign w_tick = bus.vsync & ~r_vsync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsync_q   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_vsync_q   <= bus.vsync;
            r_game_over <= &w_dead;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
        health_channel #(
            .LIVES_W   (LIVES_W),
            .MAX_LIVES (MAX_LIVES),
            .TOLERANCE (TOLERANCE),
            .IFRAMES   (IFRAMES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_tick       (w_tick),
            .i_restart    (bus.restart),
            .i_collision  (bus.collision[p]),
            .i_heal       (bus.heal[p]),
            .o_lives      (w_lives[p*LIVES_W +: LIVES_W]),
            .o_invincible (w_inv[p]),
            .o_hit        (w_hit[p]),
            .o_dead       (w_dead[p])
        );
    end

    assign bus.lives      = w_lives;
    assign bus.invincible = w_inv;
    assign bus.hit        = w_hit;
    assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_health_manager.sv
// Scoreboard bench for health_manager (TOLERANCE=2, IFRAMES=3, two players); follows HEALTH_IFRAMES_EN.
module tb_health_manager;

    localparam int NP  = 2;
    localparam int LW  = 3;
    localparam int MAX = 3;
    localparam int TOL = 2;
    localparam int IFR = 3;

    logic clk;
    logic reset;

    health_manager_if #(.NUM_PLAYERS(NP), .LIVES_W(LW)) bus ();

    health_manager #(
        .NUM_PLAYERS (NP),
        .LIVES_W     (LW),
        .MAX_LIVES   (MAX),
        .TOLERANCE   (TOL),
        .IFRAMES     (IFR),
        .CNT_W       (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NP*LW-1:0] lives;
        logic [NP-1:0]    inv;
        logic [NP-1:0]    hit;
        logic             gover_prev;
        logic             gover;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_errors = 0;

    int m_lives[NP];
    int m_run[NP];
    int m_ifr[NP];
    bit m_dead[NP];
    bit m_pend[NP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reload();
        for (int p = 0; p < NP; p++) begin
            m_lives[p] = MAX;
            m_run[p]   = 0;
            m_ifr[p]   = 0;
            m_dead[p]  = 1'b0;
            m_pend[p]  = 1'b0;
        end
    endfunction

    function automatic logic [NP*LW-1:0] model_lives();
        logic [NP*LW-1:0] v;
        for (int p = 0; p < NP; p++) v[p*LW +: LW] = LW'(m_lives[p]);
        return v;
    endfunction

    function automatic logic model_all_dead();
        logic a;
        a = 1'b1;
        for (int p = 0; p < NP; p++) a &= m_dead[p];
        return a;
    endfunction

    // Reference behaviour: run = consecutive contact ticks, ifr = invincible ticks still to serve.
    function automatic void model_tick(input logic [NP-1:0] c, input logic [NP-1:0] h);
        exp_t e;
        logic heal_req;
        e.gover_prev = model_all_dead();
        e.hit = '0;
        e.inv = '0;
        for (int p = 0; p < NP; p++) begin
            heal_req  = m_pend[p] | h[p];
            m_pend[p] = 1'b0;
            if (m_dead[p]) begin
                heal_req = 1'b0;
            end else if (m_ifr[p] > 0) begin
                m_ifr[p]--;
                m_run[p] = 0;
            end else if (c[p]) begin
                m_run[p]++;
                if (m_run[p] > TOL) begin
                    heal_req = 1'b0;
                    e.hit[p] = 1'b1;
                    m_lives[p]--;
                    m_run[p] = 0;
                    if (m_lives[p] == 0) m_dead[p] = 1'b1;
`ifdef HEALTH_IFRAMES_EN
                    else m_ifr[p] = IFR;
`endif
                end
            end else begin
                m_run[p] = 0;
            end
            if (heal_req && !m_dead[p] && m_lives[p] < MAX) m_lives[p]++;
            e.inv[p] = (m_ifr[p] > 0);
        end
        e.lives = model_lives();
        e.gover = model_all_dead();
        sbq.push_back(e);
    endfunction

    task automatic frame(input logic [NP-1:0] c, input logic [NP-1:0] h, input int hold);
        exp_t e;
        @(negedge clk);
        bus.collision = c;
        bus.heal      = h;
        bus.vsync     = 1'b1;
        model_tick(c, h);
        @(negedge clk);
        bus.heal = '0;
        e = sbq.pop_front();
        chk("lives", 32'(bus.lives), 32'(e.lives));
        chk("invincible", 32'(bus.invincible), 32'(e.inv));
        chk("hit", 32'(bus.hit), 32'(e.hit));
        chk("game_over_lag", 32'(bus.game_over), 32'(e.gover_prev));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("hold_lives", 32'(bus.lives), 32'(e.lives));
            chk("hold_hit", 32'(bus.hit), 32'd0);
        end
        bus.vsync = 1'b0;
        @(negedge clk);
        chk("game_over", 32'(bus.game_over), 32'(e.gover));
        chk("hit_clear", 32'(bus.hit), 32'd0);
    endtask

    task automatic pulse_heal(input logic [NP-1:0] h);
        @(negedge clk);
        bus.heal = h;
        for (int p = 0; p < NP; p++) if (h[p]) m_pend[p] = 1'b1;
        @(negedge clk);
        bus.heal = '0;
    endtask

    task automatic do_restart();
        exp_t e;
        @(negedge clk);
        bus.restart = 1'b1;
        model_reload();
        e.lives = model_lives();
        e.inv = '0;
        e.hit = '0;
        e.gover_prev = 1'b0;
        e.gover = 1'b0;
        sbq.push_back(e);
        @(negedge clk);
        bus.restart = 1'b0;
        e = sbq.pop_front();
        chk("restart_lives", 32'(bus.lives), 32'(e.lives));
        chk("restart_inv", 32'(bus.invincible), 32'(e.inv));
        @(negedge clk);
        chk("restart_game_over", 32'(bus.game_over), 32'(e.gover));
    endtask

    initial begin
        reset         = 1'b0;
        bus.vsync     = 1'b0;
        bus.collision = '0;
        bus.heal      = '0;
        bus.restart   = 1'b0;
        model_reload();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        chk("rst_lives", 32'(bus.lives), 32'h1b);
        chk("rst_inv", 32'(bus.invincible), 32'd0);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_game_over", 32'(bus.game_over), 32'd0);

        // Player 0 hit after three contact ticks, then the invincibility window
        repeat (3) frame(2'b01, 2'b00, 1);
        chk("p0_after_hit", 32'(bus.lives), 32'h1a);
        repeat (4) frame(2'b00, 2'b00, 1);

        // Broken contact never reaches damage
        repeat (2) frame(2'b01, 2'b00, 1);
        frame(2'b00, 2'b00, 1);
        repeat (2) frame(2'b01, 2'b00, 1);
        frame(2'b00, 2'b00, 1);

        // Heals: saturation, restore after damage, damage beats heal on the same tick
        pulse_heal(2'b10);
        frame(2'b00, 2'b00, 1);
        repeat (3) frame(2'b10, 2'b00, 1);
        repeat (3) frame(2'b00, 2'b00, 1);
        frame(2'b00, 2'b10, 1);
        chk("p1_healed", 32'(bus.lives[LW +: LW]), 32'd3);
        repeat (2) frame(2'b10, 2'b00, 1);
        frame(2'b10, 2'b10, 1);
        chk("p1_heal_dropped", 32'(bus.lives[LW +: LW]), 32'd2);
        repeat (3) frame(2'b00, 2'b00, 1);

        // Continuous contact until both players are dead
        repeat (30) frame(2'b11, 2'b00, 1);
        chk("both_dead_game_over", 32'(bus.game_over), 32'd1);
        pulse_heal(2'b11);
        frame(2'b00, 2'b00, 1);
        chk("dead_no_heal", 32'(bus.lives), 32'h00);
        do_restart();

        // Asynchronous reset in the middle of a contact run
        repeat (2) frame(2'b01, 2'b00, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reload();
        chk("async_rst_lives", 32'(bus.lives), 32'h1b);
        chk("async_rst_hit", 32'(bus.hit), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Held vsync gives one tick; two more ticks then complete the contact run
        frame(2'b01, 2'b00, 30);
        repeat (2) frame(2'b01, 2'b00, 1);
        chk("held_vsync_single_tick", 32'(bus.lives[0 +: LW]), 32'd2);
        repeat (4) frame(2'b00, 2'b00, 1);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/health_manager.md
# health_manager

Multi-player lives manager for the game logic layer; the parametrised successor to the single-player hearts counter. Each player channel counts consecutive frames of dragon contact, deducts a life once a contact tolerance is exceeded, then holds an optional invincibility window. Per-player heal requests, a game-over flag and per-hit pulses feed the HUD and the sound/flash logic. All state advances only on frame ticks derived from vsync.

## Interface
- NUM_PLAYERS, 2, number of independent player channels (1..4)
- LIVES_W, 3, width of each lives field
- MAX_LIVES, 3, lives after reset and ceiling for heals (1..2^LIVES_W-1)
- TOLERANCE, 60, consecutive contact frames absorbed before damage (0..2^CNT_W-1)
- IFRAMES, 90, invincibility frames after a hit (1..2^CNT_W-1)
- CNT_W, 7, width of the shared per-channel frame counter

- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- vsync  input  1  frame sync from the VGA timing block
- collision  input  NUM_PLAYERS  per-player dragon contact, level
- heal  input  NUM_PLAYERS  per-player heal request, single-cycle pulse
- restart  input  1  synchronous reload of all channels, level
- lives  output  NUM_PLAYERS*LIVES_W  packed lives; player p at [p*LIVES_W +: LIVES_W]
- invincible  output  NUM_PLAYERS  channel in INVULN
- hit  output  NUM_PLAYERS  one-cycle pulse when a life is deducted
- game_over  output  1  all channels DEAD

## Operation
- Frame tick: vsync registered into vsync_q; tick = vsync & ~vsync_q. Only rising vsync edges count.
- Per-channel states: ALIVE, CONTACT, INVULN, DEAD. Counter cnt (CNT_W bits).
- ALIVE, on tick: if collision and TOLERANCE==0, take damage. If collision and TOLERANCE>0, go to CONTACT with cnt=1. If no collision, stay.
- CONTACT, on tick:
  - collision && cnt<TOLERANCE: cnt+1.
  - collision && cnt==TOLERANCE: take damage.
  - no collision: go to ALIVE with cnt=0.
- Damage on the (TOLERANCE+1)th consecutive contact tick.
- Take damage: lives-1 and hit pulses for one cycle.
  - If the new lives value is 0: go to DEAD.
  - Otherwise: go to INVULN with cnt=0.
- INVULN, on tick: collision ignored; cnt+1. When cnt reaches IFRAMES-1, go to ALIVE with cnt=0, giving exactly IFRAMES ticks of invincibility.
- Heal: a pulse sets a sticky per-channel pending bit, consumed at the next tick.
  - If lives<MAX_LIVES and the state is not DEAD: lives+1.
  - If the same tick also takes damage, damage wins and the heal is discarded.
  - Lives saturate at MAX_LIVES; heal in DEAD is discarded.
- DEAD: absorbing. Only reset or restart leaves it.
- restart: every clock it is high, all channels load lives=MAX_LIVES, state ALIVE, cnt=0, and pending heals are cleared. It overrides a tick.
- game_over = AND of (state==DEAD) over all channels, registered.

## Timing
- Reset values:
  - lives = MAX_LIVES per channel; state ALIVE; cnt 0.
  - invincible 0, hit 0, game_over 0.
  - vsync_q 0, heal pending 0.
- The tick is evaluated in the first clk where vsync is sampled high; state, lives and invincible update on that edge and are visible the following cycle.
- hit is high for exactly one clk, coincident with the lives decrement.
- game_over asserts one clk after the last channel enters DEAD.
- A heal pulse arriving in the same clk as a tick applies at that tick.
- Reset asserted mid-count clears everything immediately, without waiting for clk.
- vsync held high produces one tick only.

## Configuration
- HEALTH_IFRAMES_EN defined: INVULN state and the invincible output behave as above.
- HEALTH_IFRAMES_EN undefined:
  - INVULN is not built; damage goes directly to ALIVE with cnt=0.
  - invincible is tied to 0; IFRAMES is unused.

## Structure
- Shared package health_pkg:
  - state enum (ALIVE, CONTACT, INVULN, DEAD).
  - Default widths and constants for MAX_LIVES, TOLERANCE, IFRAMES.
- One sub-module, health_channel: the per-player FSM, counter, lives register and heal pending bit.
- The top level generates NUM_PLAYERS instances and owns the vsync edge detect, tick distribution, lives packing and game_over.

## Test plan
- Bench parameters for all scenarios: TOLERANCE=2, IFRAMES=3, NUM_PLAYERS=2.
- Contact on player 0 for 3 ticks -> lives[0] 3->2 on the 3rd tick; single hit pulse; invincible[0] high for exactly 3 ticks; player 1 unchanged.
- Contact 2 ticks, gap 1 tick, contact 2 ticks -> no damage; lives stays 3.
- Heal on player 1 at lives 3 -> stays 3. Damage to 2, then heal -> 3. Heal and damage on the same tick -> lives decrements; heal dropped.
- Continuous contact on both players -> each reaches 0, enters DEAD; game_over high one clk after the second; heal ignored; restart -> lives 3/3, game_over 0.
- Reset pulsed low mid-CONTACT, and vsync held high for 10 frames' worth of clocks -> immediate reload to 3 with no ticks lost or doubled.
- Build without HEALTH_IFRAMES_EN -> invincible stays 0; continuous contact deducts a life every 3 ticks.
